linear_feature_feeder: RTL and testbench

- Responder side of the fully-connected layer's read handshake.
- Buffers pCHANNEL-wide input-feature words from the upstream conv/pool stage in a FIFO.
- On each rd_en request from the linear controller, pops exactly one word and presents it with a one-cycle data_valid pulse.
- Holds the word stable while the PE array consumes it, and tracks word position within the pIN_FEATURE frame.

---
 rtl/linear_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/linear_feature_feeder.sv | 113 +++++++++++
 tb/tb_linear_feature_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/linear_pkg.sv
// Shared types and defaults for the fully-connected layer input feeder.
// Optional build macro used by the feeder: LINEAR_FEEDER_STATS_EN.
package linear_pkg;
  localparam int pDATA_WIDTH_DEF = 8;
  localparam int pCHANNEL_DEF    = 32;
  localparam int pIN_FEATURE_DEF = 14*14*32;
  localparam int pDEPTH_DEF      = 16;

  typedef logic [pCHANNEL_DEF*pDATA_WIDTH_DEF-1:0] feature_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ISSUED = 1'b1
  } feed_state_t;

  // A one-word frame still needs a 1-bit index register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered count, head word readable combinationally.
// Power-of-two depth; pointers wrap naturally, count carries the extra bit.
module sync_fifo #(
  parameter int pWIDTH = 256,
  parameter int pDEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [pWIDTH-1:0]          push_data,
  input  logic                       pop,
  output logic [pWIDTH-1:0]          pop_data,
  output logic [$clog2(pDEPTH):0]    count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(pDEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(pDEPTH);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_DEPTH);
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end
endmodule

// File: rtl/linear_feature_feeder.sv
// Buffers upstream feature words and hands exactly one word per rd_en request to the PE array.
// Build with LINEAR_FEEDER_STATS_EN to add the stall_cnt output.
module linear_feature_feeder
  import linear_pkg::*;
#(
  parameter int pIN_FEATURE = pIN_FEATURE_DEF,
  parameter int pCHANNEL    = pCHANNEL_DEF,
  parameter int pDATA_WIDTH = pDATA_WIDTH_DEF,
  parameter int pDEPTH      = pDEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic [pCHANNEL*pDATA_WIDTH-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            rd_en,
  output logic [pCHANNEL*pDATA_WIDTH-1:0] data_out,
  output logic                            data_valid,
  output logic                            frame_last,
  output logic [$clog2(pDEPTH):0]         fifo_count,
  output logic                            empty,
  output logic                            full
`ifdef LINEAR_FEEDER_STATS_EN
  , output logic [15:0]                   stall_cnt
`endif
);
  localparam int W      = pCHANNEL * pDATA_WIDTH;
  localparam int NWORDS = pIN_FEATURE / pCHANNEL;
  localparam int IW     = cnt_width(NWORDS);
  localparam int CW     = $clog2(pDEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(pDEPTH);

  feed_state_t     state;
  logic [IW-1:0]   word_idx;
  logic [W-1:0]    head;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;

  assign push = s_valid && s_ready;
  assign pop  = (state == IDLE) && rd_en && !empty && !clear;

  sync_fifo #(
    .pWIDTH (W),
    .pDEPTH (pDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  // s_ready is registered from the next count so it is exact the cycle full changes.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CNT_ONE;
    else if (pop && !push) count_next = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_idx   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_last <= 1'b0;
      s_ready    <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      word_idx   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_last <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      s_ready    <= (count_next != CNT_DEPTH);
      data_valid <= pop;
      frame_last <= pop && (word_idx == LAST_IDX);
      if (pop) begin
        data_out <= head;
        word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_ONE;
      end
      // ISSUED blocks a held rd_en from popping a second word back-to-back.
      case (state)
        IDLE:    if (pop) state <= ISSUED;
        ISSUED:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINEAR_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && rd_en && empty && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_linear_feature_feeder.sv
// Randomized scoreboard bench for linear_feature_feeder with a queue-based reference model.
module tb_linear_feature_feeder;
  localparam int IN_F  = 64;
  localparam int CH    = 32;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int W     = CH * DW;
  localparam int NW    = IN_F / CH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear = 1'b0;
  logic [W-1:0]           s_data = '0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic                   rd_en = 1'b0;
  logic [W-1:0]           data_out;
  logic                   data_valid;
  logic                   frame_last;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   empty;
  logic                   full;
`ifdef LINEAR_FEEDER_STATS_EN
  logic [15:0]            stall_cnt;
`endif

  linear_feature_feeder #(
    .pIN_FEATURE (IN_F),
    .pCHANNEL    (CH),
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_last (frame_last),
    .fifo_count (fifo_count),
    .empty      (empty),
    .full       (full)
`ifdef LINEAR_FEEDER_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mq[$];
  int           widx;
  bit           last_pop;
  bit           sready_m;
  int           stall_m;
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model rules: a request pops only if words are stored and no pop happened the previous cycle.
  task automatic step(input bit sv, input bit re, input bit clr);
    logic [W-1:0] d;
    bit           pushed;
    bit           popped;
    d       = rnd_word();
    s_valid = sv;
    s_data  = d;
    rd_en   = re;
    clear   = clr;
    if (clr) begin
      mq.delete();
      widx     = 0;
      last_pop = 0;
      stall_m  = 0;
    end else begin
      pushed = sv && sready_m;
      popped = re && (mq.size() > 0) && !last_pop;
      if (re && !last_pop && mq.size() == 0 && stall_m < 65535) stall_m++;
      if (popped) begin
        exp_q.push_back('{d: mq.pop_front(), last: (widx == NW-1)});
        widx = (widx + 1) % NW;
      end
      if (pushed) mq.push_back(d);
      last_pop = popped;
    end
    sready_m = (mq.size() < DEPTH);
    @(posedge clk);
    #1;
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("s_ready", int'(s_ready), int'(sready_m));
`ifdef LINEAR_FEEDER_STATS_EN
    chk("stall_cnt", int'(stall_cnt), stall_m);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    s_valid = 0;
    rd_en   = 0;
    clear   = 0;
    rst_n   = 0;
    mq.delete();
    exp_q.delete();
    widx     = 0;
    last_pop = 0;
    sready_m = 0;
    stall_m  = 0;
    #2;
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_frame_last", int'(frame_last), 0);
    chk("rst_data_out_zero", int'(data_out == '0), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_data_valid: got data_valid=1 expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (data_out !== e.d || frame_last !== e.last) begin
            bad++;
            $display("FAIL word: got data=%h last=%0b expected data=%h last=%0b at %0t",
                     data_out[31:0], frame_last, e.d[31:0], e.last, $time);
          end
        end
      end else if (frame_last) begin
        total++;
        bad++;
        $display("FAIL frame_last_alone: got frame_last=1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    do_reset();
    step(0, 0, 0);

    // Three words, one held request.
    repeat (3) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Requests against an empty FIFO, then a late word.
    step(0, 0, 1);
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Fill past capacity, then pop and refill around the full boundary.
    step(0, 0, 1);
    repeat (DEPTH + 1) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // Frame wrap over four words with rd_en held high.
    step(0, 0, 1);
    repeat (4) step(1, 0, 0);
    repeat (8) step(0, 1, 0);
    step(0, 0, 0);

    // Clear with words stored and a pop in flight, then a fresh frame.
    step(0, 0, 1);
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 1, 0);
    step(0, 0, 0);

    // Asynchronous reset mid-frame.
    repeat (3) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 1, 0);
    step(0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2);
    end

    repeat (4) step(0, 0, 0);
    chk("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
